// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, parameter defaults and parity helper for the UART transmitter
// Contents: uart_tx_state_t (six FSM states), UART_CLKS_PER_BIT_DEF, UART_GAP_DEF, uart_parity()
package uart_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_GAP
   } uart_tx_state_t;
   localparam int UART_CLKS_PER_BIT_DEF = 10417;
   localparam int UART_GAP_DEF = 20000;
   // Data is zero-extended to 9 bits by the caller, so unused upper bits never disturb the result
   function automatic logic uart_parity(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter that flags the last cycle of every bit
// Ports: clk, rst_n (sync, active-low), restart (align a new bit period), bit_end (last-cycle pulse)
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic bit_end
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   logic [CW-1:0] cnt;
   assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
   // Restarting exactly at terminal count keeps every bit period the same length, so there is no drift
   always_ff @(posedge clk)
      if (!rst_n || restart || bit_end) cnt <= '0;
      else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input and post-frame idle gap
// Ports: clk, rst_n (sync, active-low), s_data/s_valid/s_ready (input handshake),
//        tx_o (registered serial line, idle high), busy (not idle), done (pulse at end of gap)
// Build option: define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd/even)
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int GAP_CYCLES   = UART_GAP_DEF,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 tx_o,
   output logic                 busy,
   output logic                 done
);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
`ifdef UART_TX_PARITY_EN
   localparam uart_tx_state_t AFTER_DATA = ST_PARITY;
`else
   localparam uart_tx_state_t AFTER_DATA = ST_STOP;
`endif

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       GAP_CYCLES < 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_tx_frame: illegal parameter set");
   end

   uart_tx_state_t       state, state_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [3:0]           idx, idx_n;
   logic [GW-1:0]        gap_cnt, gap_cnt_n;
   logic                 hs, bit_end, tx_n, done_c, last_data, last_stop;

   assign hs = s_valid && s_ready;
   assign busy = state != ST_IDLE;
   // Gated so a reset landing on the final gap cycle never emits a completion pulse
   assign done = done_c && rst_n;
   assign last_data = idx == 4'(DATA_BITS - 1);
   assign last_stop = idx == 4'(STOP_BITS - 1);

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (hs),
      .bit_end (bit_end)
   );

`ifdef UART_TX_PARITY_EN
   logic par;
   // Parity is taken from the handshake data, so later s_data changes cannot affect it
   always_ff @(posedge clk)
      if (hs) par <= uart_parity(9'(s_data), 1'(PARITY_ODD));
`endif

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      idx_n = idx;
      gap_cnt_n = gap_cnt;
      done_c = 1'b0;
      case (state)
         ST_IDLE: begin
            state_n = hs ? ST_START : ST_IDLE;
            shreg_n = hs ? s_data : shreg;
            idx_n = hs ? 4'd0 : idx;
         end
         ST_START: state_n = bit_end ? ST_DATA : ST_START;
         ST_DATA: if (bit_end) begin
            shreg_n = shreg >> 1;
            idx_n = last_data ? 4'd0 : idx + 1'b1;
            state_n = last_data ? AFTER_DATA : ST_DATA;
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: state_n = bit_end ? ST_STOP : ST_PARITY;
`endif
         ST_STOP: if (bit_end) begin
            idx_n = last_stop ? 4'd0 : idx + 1'b1;
            state_n = !last_stop ? ST_STOP : (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            gap_cnt_n = GW'(GAP_LOAD);
            done_c = last_stop && GAP_CYCLES == 0;
         end
         ST_GAP: begin
            done_c = gap_cnt == '0;
            state_n = done_c ? ST_IDLE : ST_GAP;
            gap_cnt_n = done_c ? gap_cnt : gap_cnt - 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
      // Line level is derived from the next state so tx_o changes on the same edge as the state
      tx_n = (state_n == ST_START) ? 1'b0 :
             (state_n == ST_DATA)  ? shreg_n[0] :
`ifdef UART_TX_PARITY_EN
             (state_n == ST_PARITY) ? par :
`endif
             1'b1;
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= ST_IDLE;
         tx_o <= 1'b1;
         s_ready <= 1'b0;
         shreg <= '0;
         idx <= '0;
         gap_cnt <= '0;
      end else begin
         state <= state_n;
         tx_o <= tx_n;
         s_ready <= state_n == ST_IDLE;
         shreg <= shreg_n;
         idx <= idx_n;
         gap_cnt <= gap_cnt_n;
      end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the baseband processor's debug/telemetry path. Supports configurable bit period, data width, stop-bit count, inter-frame gap and optional parity, and accepts bytes over a valid/ready handshake. It serialises one frame at a time onto `tx_o` and signals frame completion after the gap expires.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per bit period; legal range ≥2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `GAP_CYCLES`, default 20000: idle-high cycles after the stop bit(s); 0 is legal.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only with `UART_TX_PARITY_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `s_data`  in  DATA_BITS  byte to send; sampled only on the handshake cycle.
- `s_valid`  in  1  producer has data.
- `s_ready`  out  1  high only in IDLE; reset value 0, high from the first cycle after reset deassert.
- `tx_o`  out  1  serial line, registered; reset value 1 (idle high).
- `busy`  out  1  high in every state except IDLE; reset value 0.
- `done`  out  1  single-cycle pulse at the end of the gap; reset value 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE: `tx_o` = 1.
  - On `s_valid && s_ready`: latch `s_data` into the shift register, clear the bit counter, go to START.
- START: `tx_o` = 0 for one bit period, then go to DATA.
- DATA: send `DATA_BITS` bits, LSB first, one bit period each.
  - After the last bit, go to PARITY if parity is compiled in, else to STOP.
- PARITY: send one bit period of XOR of latched data, inverted when `PARITY_ODD` = 1. Then go to STOP.
- STOP: `tx_o` = 1 for `STOP_BITS` bit periods.
  - Then go to GAP, or go directly to IDLE if `GAP_CYCLES` = 0.
- GAP: `tx_o` = 1, count down `GAP_CYCLES`, then go to IDLE.
- `done` pulses on the last cycle before entering IDLE, in the last GAP cycle or, when `GAP_CYCLES` = 0, in the last STOP cycle.
- `s_valid` with `s_ready` low is ignored. The producer must hold `s_valid` until the handshake.
- Changes to `s_data` after the handshake have no effect on the frame in flight.
- Bit counter width: `$clog2(CLKS_PER_BIT)`.
- Gap counter width: `$clog2(GAP_CYCLES+1)`. Zero width is guarded to 1.
- Counters never wrap; each saturates and restarts exactly at terminal count.
- Reset mid-frame: on the next edge `tx_o` = 1, state IDLE, no `done` pulse. The partial frame is abandoned.
- Illegal or unknown state: recover to IDLE with `tx_o` = 1.

## Timing
- Handshake at edge N: `tx_o` falls at edge N+1. `s_ready` and `busy` change at edge N+1.
- Every bit occupies exactly `CLKS_PER_BIT` cycles. There is no cumulative drift across bits.
- Frame length in cycles: `CLKS_PER_BIT` × (1 + `DATA_BITS` + P + `STOP_BITS`), where P = 1 with parity, else 0.
- Handshake to `done` (inclusive): frame length + `GAP_CYCLES`.
- `s_ready` rises the cycle after `done`.
- Back-to-back: with `s_valid` held high, the next start bit begins 1 cycle after `s_ready` rises. The minimum frame-to-frame spacing is therefore frame length + `GAP_CYCLES` + 1.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists, one parity bit is inserted after the data bits, and `PARITY_ODD` selects even or odd.
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are absent. The frame is N-data-bits, no parity, `STOP_BITS` stop bits. `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` enum for the six states.
  - Localparam defaults: `UART_CLKS_PER_BIT_DEF` = 10417, `UART_GAP_DEF` = 20000.
  - Parity helper function.
- Sub-module `uart_bit_timer`:
  - Parameter `CLKS_PER_BIT`.
  - Inputs `clk`, `rst_n`, `restart`.
  - Output `bit_end`: one-cycle pulse on the last cycle of each bit period.
  - The FSM asserts `restart` on the handshake and advances state on `bit_end`.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles → `tx_o` = 1, `s_ready` = 0, `busy` = 0, `done` = 0. One cycle after release → `s_ready` = 1.
- Basic frame: `CLKS_PER_BIT` = 4, `DATA_BITS` = 8, `STOP_BITS` = 1, `GAP_CYCLES` = 6, no parity. Send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles). `done` arrives 46 cycles after the handshake.
- Parity build, `PARITY_ODD` = 0:
  - Send 0x07 → parity bit 1.
  - Rebuild with `PARITY_ODD` = 1, send 0x07 → parity bit 0.
  - Frame is 11 bit periods.
- Two stop bits with `GAP_CYCLES` = 0: send 0x3C with `DATA_BITS` = 7 → stop held 8 cycles, `done` on the last stop cycle, `s_ready` high the next cycle.
- Back-to-back with `s_valid` held high, data 0x11 then 0x22:
  - Second start bit begins exactly 1 cycle after `s_ready` rises.
  - `s_data` changed mid-frame does not alter the first frame.
- Reset in DATA bit 3: assert `rst_n` = 0 for 1 cycle → `tx_o` = 1 next edge, no `done`, `s_ready` = 1 one cycle after release. A new byte 0x5A then transmits correctly.
